// File: rtl/sram_pkg.sv
// Shared types and default geometry for the external 1M x 16 asynchronous SRAM controller.
package sram_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_RD,
    ACC_WR
  } acc_t;

  typedef struct packed {
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
    logic [1:0]             be;
  } sram_req_t;

endpackage

// File: rtl/sram_ctrl_if.sv
// Requester-side bus of the SRAM controller: per-port request lanes plus shared read return.
interface sram_ctrl_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = sram_pkg::SRAM_ADDR_W,
  parameter int DATA_W  = sram_pkg::SRAM_DATA_W
);

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_we;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0][1:0]        req_be;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             rd_valid;
  logic [DATA_W-1:0]              rd_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rd_valid, rd_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rd_valid, rd_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requesting port at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win_idx;
  logic          found;

  // First pass covers ports at/after the pointer, second pass wraps to the low ports.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    grant   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (PW'(i) >= ptr)) begin
        found   = 1'b1;
        win_idx = PW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        found   = 1'b1;
        win_idx = PW'(i);
      end
    end
    if (found && enable) begin
      grant = NUM_REQ'(1) << win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// Multi-port round-robin controller for an external async SRAM: registered pins, one access
// per cycle, and a turnaround bubble whenever a read would follow a write.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = SRAM_ADDR_W,
  parameter int DATA_W  = SRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  sram_ctrl_if.slave        bus,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_io,
  output logic              sram_ce_b,
  output logic              sram_we_b,
  output logic              sram_oe_b,
  output logic              sram_ub_b,
  output logic              sram_lb_b
);

  localparam int HALF_W = DATA_W / 2;

  acc_t               state;
  logic [NUM_REQ-1:0] winner;
  logic [NUM_REQ-1:0] grant;
  logic               winner_we;
  logic               bubble;

  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic [1:0]         sel_be;

  logic               io_oe_p1;
  logic [DATA_W-1:0]  wdata_p1;
  logic [NUM_REQ-1:0] rd_port_p1;
  logic [1:0]         rd_be_p1;

  function automatic logic [DATA_W-1:0] mask_bytes(input logic [DATA_W-1:0] d,
                                                   input logic [1:0]        be);
    return {be[1] ? d[DATA_W-1:HALF_W] : {(DATA_W-HALF_W){1'b0}},
            be[0] ? d[HALF_W-1:0]      : {HALF_W{1'b0}}};
  endfunction

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .enable  (!rst),
    .advance (|grant),
    .grant   (winner)
  );

  // A read right after a write cycle is held off one cycle so the bus can turn around.
  assign winner_we     = |(winner & bus.req_we);
  assign bubble        = (state == ACC_WR) && (|winner) && !winner_we;
  assign grant         = bubble ? '0 : winner;
  assign bus.req_ready = grant;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_we    = bus.req_we[i];
        sel_addr  = bus.req_addr[i];
        sel_wdata = bus.req_wdata[i];
        sel_be    = bus.req_be[i];
      end
    end
  end

  // ---- p0 -> p1: grant becomes the pin state of the next cycle ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC_IDLE;
      sram_ce_b <= 1'b1;
      sram_we_b <= 1'b1;
      sram_oe_b <= 1'b1;
      sram_ub_b <= 1'b1;
      sram_lb_b <= 1'b1;
      sram_addr <= '0;
      io_oe_p1  <= 1'b0;
    end else if (|grant) begin
      state     <= sel_we ? ACC_WR : ACC_RD;
      sram_ce_b <= 1'b0;
      sram_we_b <= !sel_we;
      sram_oe_b <= sel_we;
      sram_ub_b <= !sel_be[1];
      sram_lb_b <= !sel_be[0];
      sram_addr <= sel_addr;
      io_oe_p1  <= sel_we;
    end else begin
      state     <= ACC_IDLE;
      sram_ce_b <= 1'b1;
      sram_we_b <= 1'b1;
      sram_oe_b <= 1'b1;
      sram_ub_b <= 1'b1;
      sram_lb_b <= 1'b1;
      io_oe_p1  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    wdata_p1   <= sel_wdata;
    rd_port_p1 <= grant;
    rd_be_p1   <= sel_be;
  end

  assign sram_io = io_oe_p1 ? wdata_p1 : 'z;

  // ---- p1 -> p2: sample the SRAM at the end of a read cycle ----
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_valid <= '0;
      bus.rd_data  <= '0;
    end else if (state == ACC_RD) begin
      bus.rd_valid <= rd_port_p1;
      bus.rd_data  <= mask_bytes(sram_io, rd_be_p1);
    end else begin
      bus.rd_valid <= '0;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: async SRAM pin model plus a transaction-level reference model of
// arbitration, turnaround, pin timing and read return.
module tb_sram_ctrl;
  import sram_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = SRAM_ADDR_W;
  localparam int DATA_W  = SRAM_DATA_W;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int K_NONE  = 0;
  localparam int K_RD    = 1;
  localparam int K_WR    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_ctrl_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic [ADDR_W-1:0] sram_addr;
  wire  [DATA_W-1:0] sram_io;
  logic sram_ce_b, sram_we_b, sram_oe_b, sram_ub_b, sram_lb_b;

  sram_ctrl #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sram_addr (sram_addr),
    .sram_io   (sram_io),
    .sram_ce_b (sram_ce_b),
    .sram_we_b (sram_we_b),
    .sram_oe_b (sram_oe_b),
    .sram_ub_b (sram_ub_b),
    .sram_lb_b (sram_lb_b)
  );

  // Asynchronous SRAM: drives the bus on output enable, latches byte lanes mid-cycle on write.
  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];

  assign sram_io = (!sram_ce_b && !sram_oe_b && sram_we_b) ? mem[sram_addr] : 'z;

  always @(negedge clk) begin
    if (!sram_ce_b && !sram_we_b) begin
      if (!sram_lb_b) mem[sram_addr][7:0]  <= sram_io[7:0];
      if (!sram_ub_b) mem[sram_addr][15:8] <= sram_io[15:8];
    end
  end

  typedef struct {
    int                due;
    int                port;
    logic [DATA_W-1:0] data;
  } rd_exp_t;

  rd_exp_t           rdq[$];
  int                tests = 0;
  int                fails = 0;
  int                cyc = 0;
  int                ptr_m = 0;
  int                prev_kind = K_NONE;
  sram_req_t         prev;
  logic [ADDR_W-1:0] last_addr_m = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic sram_req_t rd(input logic [ADDR_W-1:0] a, input logic [1:0] be);
    sram_req_t r;
    r.we = 1'b0; r.addr = a; r.wdata = '0; r.be = be;
    return r;
  endfunction

  function automatic sram_req_t wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                   input logic [1:0] be);
    sram_req_t r;
    r.we = 1'b1; r.addr = a; r.wdata = d; r.be = be;
    return r;
  endfunction

  task automatic set_req(input int p, input logic v, input sram_req_t r);
    bus.req_valid[p] = v;
    bus.req_we[p]    = r.we;
    bus.req_addr[p]  = r.addr;
    bus.req_wdata[p] = r.wdata;
    bus.req_be[p]    = r.be;
  endtask

  task automatic idle_all();
    for (int p = 0; p < NUM_REQ; p++) set_req(p, 1'b0, rd('0, 2'b00));
  endtask

  task automatic drive_random();
    sram_req_t r;
    for (int p = 0; p < NUM_REQ; p++) begin
      r.we    = 1'($urandom_range(0, 1));
      r.addr  = ($urandom_range(0, 7) == 0) ? (ADDR_W'(DEPTH - 1) - ADDR_W'($urandom_range(0, 3)))
                                            : ADDR_W'($urandom_range(0, 63));
      r.wdata = DATA_W'($urandom);
      r.be    = 2'($urandom_range(0, 3));
      set_req(p, ($urandom_range(0, 3) != 0), r);
    end
  endtask

  // One clock: check this cycle's outputs against the model, then advance the model.
  task automatic step();
    logic [NUM_REQ-1:0] exp_ready;
    logic [NUM_REQ-1:0] exp_rdv;
    logic [DATA_W-1:0]  exp_rdd;
    logic [DATA_W-1:0]  d;
    logic [4:0]         exp_pins;
    sram_req_t          r;
    int                 w;
    @(negedge clk);
    exp_ready = '0;
    w = -1;
    if (!rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int p = (ptr_m + k) % NUM_REQ;
        if (w < 0 && bus.req_valid[p]) w = p;
      end
      if (w >= 0 && !(prev_kind == K_WR && !bus.req_we[w])) exp_ready[w] = 1'b1;
    end
    chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));

    case (prev_kind)
      K_RD:    exp_pins = {1'b0, 1'b1, 1'b0, ~prev.be[1], ~prev.be[0]};
      K_WR:    exp_pins = {1'b0, 1'b0, 1'b1, ~prev.be[1], ~prev.be[0]};
      default: exp_pins = 5'b11111;
    endcase
    chk("pins_ce_we_oe_ub_lb", 64'({sram_ce_b, sram_we_b, sram_oe_b, sram_ub_b, sram_lb_b}),
        64'(exp_pins));
    chk("sram_addr", 64'(sram_addr), 64'(last_addr_m));
    if (prev_kind == K_WR) chk("io_wdata", 64'(sram_io), 64'(prev.wdata));

    exp_rdv = '0;
    exp_rdd = '0;
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      exp_rdv[rdq[0].port] = 1'b1;
      exp_rdd = rdq[0].data;
      void'(rdq.pop_front());
    end
    chk("rd_valid", 64'(bus.rd_valid), 64'(exp_rdv));
    if (exp_rdv != '0) chk("rd_data", 64'(bus.rd_data), 64'(exp_rdd));

    if (rst) begin
      ptr_m       = 0;
      prev_kind   = K_NONE;
      last_addr_m = '0;
      rdq.delete();
    end else if (exp_ready != '0) begin
      r.we    = bus.req_we[w];
      r.addr  = bus.req_addr[w];
      r.wdata = bus.req_wdata[w];
      r.be    = bus.req_be[w];
      ptr_m   = (w + 1) % NUM_REQ;
      if (r.we) begin
        if (r.be[0]) ref_mem[r.addr][7:0]  = r.wdata[7:0];
        if (r.be[1]) ref_mem[r.addr][15:8] = r.wdata[15:8];
        prev_kind = K_WR;
      end else begin
        d = ref_mem[r.addr];
        rdq.push_back('{cyc + 2, w, {r.be[1] ? d[15:8] : 8'h00, r.be[0] ? d[7:0] : 8'h00}});
        prev_kind = K_RD;
      end
      prev        = r;
      last_addr_m = r.addr;
    end else begin
      prev_kind = K_NONE;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = DATA_W'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[16]     = 16'hBEEF;
    ref_mem[16] = 16'hBEEF;
    prev        = rd('0, 2'b00);

    // Reset with requests pending: nothing may be granted, pins idle.
    rst = 1'b1;
    set_req(0, 1'b1, rd(20'h00010, 2'b11));
    set_req(1, 1'b1, wr(20'h00011, 16'h0F0F, 2'b11));
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;
    idle_all();
    chk("reset_rd_data", 64'(bus.rd_data), 64'h0);

    // Single read of the preloaded word.
    set_req(0, 1'b1, rd(20'h00010, 2'b11));
    step();
    idle_all();
    repeat (3) step();

    // Write then immediate read on the other port: one bubble.
    set_req(0, 1'b1, wr(20'h00005, 16'h1234, 2'b11));
    step();
    idle_all();
    set_req(1, 1'b1, rd(20'h00005, 2'b11));
    step();
    step();
    idle_all();
    repeat (3) step();

    // Byte-lane write over a full word, then full and upper-only reads.
    set_req(0, 1'b1, wr(20'h00020, 16'h5555, 2'b11));
    step();
    set_req(0, 1'b1, wr(20'h00020, 16'hAAAA, 2'b01));
    step();
    idle_all();
    step();
    set_req(0, 1'b1, rd(20'h00020, 2'b11));
    step();
    set_req(0, 1'b1, rd(20'h00020, 2'b10));
    step();
    idle_all();
    repeat (3) step();

    // Both ports reading continuously: strict alternation.
    set_req(0, 1'b1, rd(20'h00010, 2'b11));
    set_req(1, 1'b1, rd(20'h00005, 2'b11));
    repeat (8) step();
    idle_all();
    repeat (3) step();

    // Port 0 streaming writes with a pending read on port 1.
    for (int k = 0; k < 6; k++) begin
      set_req(0, 1'b1, wr(ADDR_W'(48 + k), DATA_W'($urandom), 2'b11));
      set_req(1, 1'b1, rd(20'h00030, 2'b11));
      step();
    end
    idle_all();
    repeat (3) step();

    // Reset the cycle after a read grant: read dropped, pointer back to port 0.
    set_req(0, 1'b1, rd(20'h00010, 2'b11));
    step();
    rst = 1'b1;
    set_req(1, 1'b1, rd(20'h00005, 2'b11));
    step();
    rst = 1'b0;
    step();
    idle_all();
    repeat (3) step();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 500; n++) begin
      drive_random();
      step();
    end
    idle_all();
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Multi-port controller for the external 1M x 16 asynchronous SRAM. Arbitrates round-robin between NUM_REQ on-chip requesters (e.g. frame-buffer writer, VGA scan-out reader) and drives the SRAM pins from registers. Sustains one access per cycle and inserts a bus-turnaround bubble on write-to-read. Sits between the ray-tracer/display clients and the board SRAM pins.

## Interface
- NUM_REQ, 2, number of requester ports (2..8)
- ADDR_W, 20, SRAM word address width
- DATA_W, 16, SRAM data width
- clk  in  1  system clock; reset is synchronous and active-high
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  request pending per port
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ x ADDR_W  word address per port
- req_wdata  in  NUM_REQ x DATA_W  write data per port
- req_be  in  NUM_REQ x 2  byte enables; [1] = upper byte, [0] = lower byte
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid & ready
- rd_valid  out  NUM_REQ  one-hot; read data for that port is on rd_data
- rd_data  out  DATA_W  read return data
- sram_addr  out  ADDR_W  registered SRAM address
- sram_io  inout  DATA_W  driven only during write access cycles, else high-Z
- sram_ce_b, sram_we_b, sram_oe_b, sram_ub_b, sram_lb_b  out  1 each  registered, active-low

## Operation
- Access state (registered): ACC_IDLE, ACC_RD, ACC_WR. The state reflects what the pins do in the current cycle.
- Arbitration: a round-robin pointer holds the highest-priority port. The winner is the first valid port at or after the pointer, wrapping.
- Grant rule:
  - In cycle t, req_ready is asserted for the winner unless the current state is ACC_WR and the winner is a read.
  - In that case no port is granted (bubble), the pointer is held, and the next state is ACC_IDLE.
- On a grant to port i, the pointer becomes (i+1) mod NUM_REQ. With no grant, the pointer is unchanged.
- req_ready depends combinationally on req_valid, req_we and state. Requesters must not make req_valid depend on req_ready.
- Granted read → next state ACC_RD: ce_b=0, oe_b=0, we_b=1, ub_b/lb_b = ~be, io high-Z.
- Granted write → next state ACC_WR: ce_b=0, we_b=0, oe_b=1, io driven with wdata, ub_b/lb_b = ~be.
- No grant → ACC_IDLE: all control pins 1, io high-Z, sram_addr holds its last value.
- Read return:
  - sram_io is sampled at the end of an ACC_RD cycle.
  - rd_data bytes whose be was 0 return 8'h00.
  - rd_valid is pulsed for exactly one cycle to the granted port.
- Requester order is not reordered: one access is in flight per cycle, and reads return in grant order.

## Timing
- Reset values: req_ready=0 during rst, rd_valid=0, rd_data=0, state ACC_IDLE, all sram_*_b=1, sram_addr=0, io high-Z, pointer=0.
- Read latency:
  - grant in cycle t;
  - pins asserted in t+1;
  - rd_valid/rd_data in t+2.
- Write: grant in t; we_b low and io driven for exactly cycle t+1.
- Throughput:
  - back-to-back reads, writes, or read-then-write: one grant per cycle;
  - write-then-read: exactly one ACC_IDLE cycle between them.
- Simultaneous valid on all ports: grants rotate strictly. No port waits more than NUM_REQ grants plus one bubble.
- Reset mid-operation:
  - in-flight reads produce no rd_valid;
  - pins return to the idle state on the cycle after rst is sampled;
  - a write in flight may be truncated.

## Structure
- sram_pkg holds: ADDR_W and DATA_W defaults, the acc_t enum {ACC_IDLE, ACC_RD, ACC_WR}, and a packed sram_req_t {we, addr, wdata, be}.
- Sub-module rr_arbiter: parameterized NUM_REQ; inputs req vector, enable, and advance; outputs one-hot grant; owns the pointer.
- Pin registers, turnaround rule and read-return pipeline stay in sram_ctrl. The tri-state lives in sram_ctrl as a single assign on an output-enable register.

## Test plan
- Single read, port 0, addr 20'h00010 preloaded with 16'hBEEF, be=2'b11 → ready at t, oe_b=0 at t+1, rd_valid[0] with 16'hBEEF at t+2.
- Write 16'h1234 to 20'h00005 (be=2'b11) then immediate read from port 1 same addr → one ACC_IDLE bubble; rd_data=16'h1234; sram_io never driven while oe_b=0.
- Byte write be=2'b01 of 16'hAAAA over 16'h5555, read with be=2'b11 → 16'h55AA; read with be=2'b10 → 16'h5500.
- Both ports hold valid reads for 8 cycles → grants alternate 0,1,0,1…; 8 rd_valid pulses in grant order, one per cycle after 2-cycle latency.
- Continuous writes on port 0, read pending on port 1 → port 1 read granted within 2 cycles (bubble then grant); no starvation.
- Assert rst the cycle after a read grant → no rd_valid; all control pins 1 and io high-Z on the next cycle; pointer=0.
